tdm_demux4: RTL and testbench

Receive-side partner of the 4:1 channel multiplexer. Accepts a time-division-multiplexed stream of four slots (slot 0..3, frame-marked on slot 0) and rebuilds the four channel words. The four words are presented together as one parallel output. Sits at the far end of a serial link whose transmitter scans a 4:1 mux with a 2-bit select counter.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_demux4_demux1_4.sv | 14 +
 rtl/tdm_demux4.sv | 100 ++++++++++
 tb/tb_tdm_demux4.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the 4-slot TDM receive path.
// Slot indices, the receiver state encoding and the slot-to-one-hot map live here.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    HUNT,
    RECV
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] one;
    one = NUM_CH'(1);
    return one << sel;
  endfunction

endpackage

// File: rtl/tdm_demux4_demux1_4.sv
// Combinational 1:4 decoder: turns a slot index plus enable into a one-hot write enable.
module demux1_4
  import tdm_pkg::*;
(
  input  logic [SEL_W-1:0]  select,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot = en ? onehot4(select) : '0;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: locks onto the slot-0 marker, collects four slot words
// in a shadow buffer and publishes them together as one parallel word per completed frame.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        din,
  input  logic                     valid,
  input  logic                     frame_start,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     frame_valid,
  output logic [NUM_CH-1:0]        ch_strobe,
  output logic [SEL_W-1:0]         select,
  output logic                     sync_err
);

  state_t            state, state_next;
  logic [SEL_W-1:0]  sel_next, wr_sel;
  logic              wr_en, err_next, commit, clear_shadow;
  logic [NUM_CH-1:0] wr_onehot;
  logic [DATA_W-1:0] shadow [NUM_CH];

  logic resync, missing;
  assign resync  = (state == RECV) && valid && frame_start && (select != '0);
  assign missing = (state == RECV) && valid && !frame_start && (select == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT: if (valid && frame_start) state_next = RECV;
      RECV: if (missing) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // A marker beat (fresh lock or resync) always lands in slot 0 and restarts the count.
  always_comb begin
    wr_en        = 1'b0;
    wr_sel       = select;
    sel_next     = select;
    err_next     = 1'b0;
    commit       = 1'b0;
    clear_shadow = 1'b0;
    if (valid) begin
      if ((state == HUNT && frame_start) || resync) begin
        wr_en        = 1'b1;
        wr_sel       = '0;
        sel_next     = SEL_W'(1);
        err_next     = resync;
        clear_shadow = resync;
      end else if (missing) begin
        err_next = 1'b1;
      end else if (state == RECV) begin
        wr_en    = 1'b1;
        sel_next = select + SEL_W'(1);
        commit   = (select == SEL_W'(NUM_CH-1));
      end
    end
  end

  demux1_4 u_demux (
    .select (wr_sel),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  // The last slot goes straight from din into dout so all channels change on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout        <= '0;
      frame_valid <= 1'b0;
      ch_strobe   <= '0;
      select      <= '0;
      sync_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      ch_strobe   <= wr_onehot;
      sync_err    <= err_next;
      frame_valid <= commit;
      select      <= sel_next;
      if (clear_shadow)
        for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      for (int i = 0; i < NUM_CH; i++)
        if (wr_onehot[i]) shadow[i] <= din;
      if (commit) begin
        for (int i = 0; i < NUM_CH-1; i++) dout[i*DATA_W +: DATA_W] <= shadow[i];
        dout[(NUM_CH-1)*DATA_W +: DATA_W] <= din;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (DATA_W=1): per-beat checks of strobes, select and error pulses,
// with expected frame words queued at stimulus time and popped when frame_valid fires.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] din;
  logic       valid;
  logic       frame_start;
  logic [3:0] dout;
  logic       frame_valid;
  logic [3:0] ch_strobe;
  logic [1:0] select;
  logic       sync_err;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] held_dout = 4'b0000;

  tdm_demux4 #(.DATA_W(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .valid       (valid),
    .frame_start (frame_start),
    .dout        (dout),
    .frame_valid (frame_valid),
    .ch_strobe   (ch_strobe),
    .select      (select),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic d, input logic fs,
                               input logic push, input logic [3:0] push_val);
    @(negedge clk);
    reset       = rst;
    valid       = v;
    din         = d;
    frame_start = fs;
    if (push) exp_q.push_back(push_val);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_strobe,
                             input logic [1:0] exp_sel, input logic exp_err, input logic exp_fv);
    check({tag, ".strobe"}, 32'(ch_strobe), 32'(exp_strobe));
    check({tag, ".select"}, 32'(select), 32'(exp_sel));
    check({tag, ".sync_err"}, 32'(sync_err), 32'(exp_err));
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'(exp_fv));
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, ".queue_empty"}, 32'(1), 32'(0));
      end else begin
        held_dout = exp_q.pop_front();
      end
    end
    check({tag, ".dout"}, 32'(dout), 32'(held_dout));
  endtask

  task automatic beat(input string tag, input logic v, input logic d, input logic fs,
                      input logic [3:0] exp_strobe, input logic [1:0] exp_sel,
                      input logic exp_err, input logic exp_fv, input logic [3:0] push_val);
    applyStimulus(1'b0, v, d, fs, exp_fv, push_val);
    checkOutput(tag, exp_strobe, exp_sel, exp_err, exp_fv);
  endtask

  task automatic doReset(input string tag, input logic v, input logic d, input logic fs);
    applyStimulus(1'b1, v, d, fs, 1'b0, 4'b0000);
    held_dout = 4'b0000;
    exp_q.delete();
    checkOutput(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; din = 1'b0; frame_start = 1'b0;

    doReset("reset", 1'b0, 1'b0, 1'b0);

    beat("nrm0", 1, 1, 1, 4'b0001, 2'd1, 0, 0, 4'h0);
    beat("nrm1", 1, 0, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    beat("nrm2", 1, 1, 0, 4'b0100, 2'd3, 0, 0, 4'h0);
    beat("nrm3", 1, 1, 0, 4'b1000, 2'd0, 0, 1, 4'b1101);

    beat("gap0", 1, 1, 1, 4'b0001, 2'd1, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) beat("gapidle0", 0, 0, 0, 4'b0000, 2'd1, 0, 0, 4'h0);
    beat("gap1", 1, 0, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) beat("gapidle1", 0, 1, 1, 4'b0000, 2'd2, 0, 0, 4'h0);
    beat("gap2", 1, 1, 0, 4'b0100, 2'd3, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) beat("gapidle2", 0, 0, 0, 4'b0000, 2'd3, 0, 0, 4'h0);
    beat("gap3", 1, 1, 0, 4'b1000, 2'd0, 0, 1, 4'b1101);
    for (int i = 0; i < 3; i++) beat("gapidle3", 0, 0, 0, 4'b0000, 2'd0, 0, 0, 4'h0);

    beat("b2bA0", 1, 1, 1, 4'b0001, 2'd1, 0, 0, 4'h0);
    beat("b2bA1", 1, 0, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    beat("b2bA2", 1, 1, 0, 4'b0100, 2'd3, 0, 0, 4'h0);
    beat("b2bA3", 1, 1, 0, 4'b1000, 2'd0, 0, 1, 4'b1101);
    beat("b2bB0", 1, 0, 1, 4'b0001, 2'd1, 0, 0, 4'h0);
    beat("b2bB1", 1, 1, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    beat("b2bB2", 1, 1, 0, 4'b0100, 2'd3, 0, 0, 4'h0);
    beat("b2bB3", 1, 0, 0, 4'b1000, 2'd0, 0, 1, 4'b0110);

    doReset("reset2", 1'b0, 1'b0, 1'b0);
    beat("early0", 1, 1, 1, 4'b0001, 2'd1, 0, 0, 4'h0);
    beat("early1", 1, 1, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    beat("earlyM", 1, 0, 1, 4'b0001, 2'd1, 1, 0, 4'h0);
    beat("early2", 1, 1, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    beat("early3", 1, 0, 0, 4'b0100, 2'd3, 0, 0, 4'h0);
    beat("early4", 1, 1, 0, 4'b1000, 2'd0, 0, 1, 4'b1010);

    beat("miss0", 1, 1, 0, 4'b0000, 2'd0, 1, 0, 4'h0);
    beat("hunt0", 1, 1, 0, 4'b0000, 2'd0, 0, 0, 4'h0);
    beat("huntidle", 0, 0, 1, 4'b0000, 2'd0, 0, 0, 4'h0);
    beat("hunt1", 1, 0, 0, 4'b0000, 2'd0, 0, 0, 4'h0);

    beat("mid0", 1, 1, 1, 4'b0001, 2'd1, 0, 0, 4'h0);
    beat("mid1", 1, 1, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    doReset("midreset", 1'b1, 1'b1, 1'b1);
    beat("post0", 1, 0, 1, 4'b0001, 2'd1, 0, 0, 4'h0);
    beat("post1", 1, 0, 0, 4'b0010, 2'd2, 0, 0, 4'h0);
    beat("post2", 1, 0, 0, 4'b0100, 2'd3, 0, 0, 4'h0);
    beat("post3", 1, 1, 0, 4'b1000, 2'd0, 0, 1, 4'b1000);
    beat("postidle", 0, 0, 0, 4'b0000, 2'd0, 0, 0, 4'h0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
